// File: rtl/xor_stream_chk.sv
// xor_stream_chk: framed XOR checksum engine with parity, beat count and overflow flag behind a valid/ready result port.
module xor_stream_chk #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  localparam logic ACC = 1'b0;
  localparam logic HOLD = 1'b1;
  logic             state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;
  logic [WIDTH-1:0] nxt_sum;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_ovf;
  assign in_ready = state == ACC;
  assign out_valid = state == HOLD;
  assign nxt_sum = acc ^ in_data;
  assign nxt_cnt = cnt + CNT_W'(1);
  assign nxt_ovf = ovf_acc | (&cnt);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACC;
      acc        <= '0;
      cnt        <= '0;
      ovf_acc    <= 1'b0;
      out_sum    <= '0;
      out_parity <= 1'b0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
    end else if (clr) begin
      state   <= ACC;
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
    end else if (state == ACC && in_valid) begin
      if (in_last) begin
        out_sum    <= nxt_sum;
        out_parity <= (^nxt_sum) ^ (PARITY_ODD != 0);
        out_count  <= nxt_cnt;
        out_ovf    <= nxt_ovf;
        acc        <= '0;
        cnt        <= '0;
        ovf_acc    <= 1'b0;
        state      <= HOLD;
      end else begin
        acc     <= nxt_sum;
        cnt     <= nxt_cnt;
        ovf_acc <= nxt_ovf;
      end
    end else if (state == HOLD && out_ready) begin
      state <= ACC;
    end
  end
endmodule

// File: tb/tb_xor_stream_chk.sv
// tb_xor_stream_chk: scoreboard bench driving three parameter variants of xor_stream_chk with a shared stimulus stream.
module tb_xor_stream_chk;
  logic       clk = 1'b0;
  logic       rst_n, clr, in_valid, in_last, out_ready;
  logic [7:0] in_data;
  logic       in_ready_a, out_valid_a, out_parity_a, out_ovf_a;
  logic [7:0] out_sum_a, out_count_a;
  logic       in_ready_b, out_valid_b, out_parity_b, out_ovf_b;
  logic [7:0] out_sum_b, out_count_b;
  logic       in_ready_c, out_valid_c, out_parity_c, out_ovf_c;
  logic [7:0] out_sum_c;
  logic [1:0] out_count_c;
  typedef struct {logic [7:0] sum; int n;} res_t;
  res_t       sb[$];
  res_t       e;
  logic [7:0] m_acc;
  int         m_n;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  xor_stream_chk #(.WIDTH(8), .CNT_W(8), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_parity(out_parity_a), .out_count(out_count_a), .out_ovf(out_ovf_a));
  xor_stream_chk #(.WIDTH(8), .CNT_W(8), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_parity(out_parity_b), .out_count(out_count_b), .out_ovf(out_ovf_b));
  xor_stream_chk #(.WIDTH(8), .CNT_W(2), .PARITY_ODD(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_sum(out_sum_c), .out_parity(out_parity_c), .out_count(out_count_c), .out_ovf(out_ovf_c));

  // A result is consumed when it is valid and out_ready is high at the edge, unless clr discards it.
  always @(negedge clk) begin
    if (rst_n && !clr && out_valid_a && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got sum=%h count=%0d", out_sum_a, out_count_a);
      end else begin
        e = sb.pop_front();
        if ({out_sum_a, out_parity_a, out_count_a, out_ovf_a} !== {e.sum, ^e.sum, e.n[7:0], e.n > 255}) begin
          errors++;
          $display("FAIL result_a got %h/%b/%0d/%b exp %h/%b/%0d/%b", out_sum_a, out_parity_a, out_count_a,
                   out_ovf_a, e.sum, ^e.sum, e.n[7:0], e.n > 255);
        end
        checks++;
        if ({out_valid_b, in_ready_b, out_sum_b, out_parity_b, out_count_b, out_ovf_b} !==
            {1'b1, 1'b0, e.sum, ~^e.sum, e.n[7:0], e.n > 255}) begin
          errors++;
          $display("FAIL result_odd got %b/%h/%b/%0d/%b exp 1/%h/%b/%0d/%b", out_valid_b, out_sum_b,
                   out_parity_b, out_count_b, out_ovf_b, e.sum, ~^e.sum, e.n[7:0], e.n > 255);
        end
        checks++;
        if ({out_valid_c, in_ready_c, out_sum_c, out_parity_c, out_count_c, out_ovf_c} !==
            {1'b1, 1'b0, e.sum, ^e.sum, e.n[1:0], e.n > 3}) begin
          errors++;
          $display("FAIL result_cnt2 got %b/%h/%b/%0d/%b exp 1/%h/%b/%0d/%b", out_valid_c, out_sum_c,
                   out_parity_c, out_count_c, out_ovf_c, e.sum, ^e.sum, e.n[1:0], e.n > 3);
        end
      end
    end
  end

  task automatic model_reset();
    m_acc = 8'h00;
    m_n = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int k = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    while (!in_ready_a && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k == 50) begin
      errors++;
      $display("FAIL accept_timeout got in_ready=0 exp 1 data=%h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_acc ^= d;
    m_n++;
    if (last) begin
      sb.push_back('{sum: m_acc, n: m_n});
      model_reset();
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!in_ready_a && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k == 50) begin
      errors++;
      $display("FAIL idle_timeout got in_ready=0 exp 1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_last = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    checks++;
    if ({in_ready_a, out_valid_a, out_sum_a, out_parity_a, out_count_a, out_ovf_a, out_parity_b} !== {2'b10, 8'h00, 1'b0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b sum=%h par=%b cnt=%0d ovf=%b parb=%b exp 1 0 00 0 0 0 0",
               in_ready_a, out_valid_a, out_sum_a, out_parity_a, out_count_a, out_ovf_a, out_parity_b);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignored_word got out_valid=%b exp 0", out_valid_a);
    end
  endtask

  task automatic test_basic();
    send(8'h0F, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h55, 1'b1);
    checks++;
    if ({out_valid_a, in_ready_a, out_sum_a, out_parity_a, out_count_a, out_ovf_a} !== {2'b10, 8'hAA, 1'b0, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL basic_latency got vld=%b rdy=%b sum=%h par=%b cnt=%0d ovf=%b exp 1 0 aa 0 3 0",
               out_valid_a, in_ready_a, out_sum_a, out_parity_a, out_count_a, out_ovf_a);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      errors++;
      $display("FAIL basic_release got vld=%b rdy=%b exp 0 1", out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_single();
    send(8'h01, 1'b1);
    checks++;
    if ({out_sum_a, out_parity_a, out_parity_b, out_count_a} !== {8'h01, 2'b10, 8'd1}) begin
      errors++;
      $display("FAIL single_word got sum=%h par=%b parodd=%b cnt=%0d exp 01 1 0 1", out_sum_a, out_parity_a,
               out_parity_b, out_count_a);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'h12, 1'b0);
    send(8'h34, 1'b1);
    in_valid = 1'b1;
    in_data = 8'h99;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready_a, out_valid_a, out_sum_a, out_count_a} !== {2'b01, 8'h26, 8'd2}) begin
        errors++;
        $display("FAIL backpressure_hold cycle %0d got rdy=%b vld=%b sum=%h cnt=%0d exp 0 1 26 2", i, in_ready_a,
                 out_valid_a, out_sum_a, out_count_a);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready_a, out_valid_a} !== 2'b10) begin
      errors++;
      $display("FAIL backpressure_release got rdy=%b vld=%b exp 1 0", in_ready_a, out_valid_a);
    end
    send(8'h99, 1'b1);
    checks++;
    if ({out_valid_a, out_sum_a} !== {1'b1, 8'h99}) begin
      errors++;
      $display("FAIL backpressure_next got vld=%b sum=%h exp 1 99", out_valid_a, out_sum_a);
    end
    wait_idle();
  endtask

  task automatic test_clr();
    send(8'h33, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
    in_valid = 1'b1;
    in_data = 8'h77;
    in_last = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    send(8'h44, 1'b1);
    checks++;
    if ({out_valid_a, out_sum_a, out_count_a} !== {1'b1, 8'h44, 8'd1}) begin
      errors++;
      $display("FAIL clr_discard got vld=%b sum=%h cnt=%0d exp 1 44 1", out_valid_a, out_sum_a, out_count_a);
    end
    wait_idle();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) send(8'h01, i == 4);
    checks++;
    if ({out_sum_c, out_count_c, out_ovf_c, out_ovf_a} !== {8'h01, 2'd1, 2'b10}) begin
      errors++;
      $display("FAIL ovf_wrap got sum=%h cnt=%0d ovf=%b ovf8=%b exp 01 1 1 0", out_sum_c, out_count_c, out_ovf_c,
               out_ovf_a);
    end
    wait_idle();
    for (int i = 0; i < 3; i++) send(8'h01, i == 2);
    checks++;
    if ({out_count_c, out_ovf_c} !== {2'd3, 1'b0}) begin
      errors++;
      $display("FAIL ovf_clear got cnt=%0d ovf=%b exp 3 0", out_count_c, out_ovf_c);
    end
    wait_idle();
  endtask

  task automatic test_async_reset();
    send(8'h11, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_a, out_valid_a, out_sum_a, out_count_a} !== {2'b10, 8'h00, 8'd0}) begin
      errors++;
      $display("FAIL async_reset_frame got rdy=%b vld=%b sum=%h cnt=%0d exp 1 0 00 0", in_ready_a, out_valid_a,
               out_sum_a, out_count_a);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    send(8'h22, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_a, out_sum_a, out_parity_a, out_count_a, out_ovf_a, out_parity_b} !== {1'b0, 8'h00, 1'b0, 8'd0, 2'b00}) begin
      errors++;
      $display("FAIL async_reset_hold got vld=%b sum=%h par=%b cnt=%0d ovf=%b exp 0 00 0 0 0", out_valid_a,
               out_sum_a, out_parity_a, out_count_a, out_ovf_a);
    end
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'hA5, 1'b1);
    checks++;
    if ({out_sum_a, out_parity_a, out_count_a} !== {8'hA5, 1'b0, 8'd1}) begin
      errors++;
      $display("FAIL post_reset_frame got sum=%h par=%b cnt=%0d exp a5 0 1", out_sum_a, out_parity_a, out_count_a);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_clr();
    test_overflow();
    test_async_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xor_stream_chk.md
Name: xor_stream_chk

Overview:
- Parametrised successor to the single-bit XOR gate: a WIDTH-bit XOR checksum engine over framed word streams.
- XOR-accumulates every accepted word of a frame. On the last word, it presents checksum, reduction parity, beat count and overflow flag through a valid/ready result port.
- Sits between a streaming source and a checker or display stage in the lab designs.

Parameters:
WIDTH, 8, data and checksum width in bits (>=1)
CNT_W, 8, beat counter width in bits (>=1)
PARITY_ODD, 0, 0 = out_parity is the even-parity bit (XOR of checksum bits); 1 = inverted (odd sense)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear: abort the current frame and drop any pending result
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word
in_data  input  WIDTH  input word
in_last  input  1  word is the final word of its frame
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_sum  output  WIDTH  XOR of all words in the frame
out_parity  output  1  reduction XOR of out_sum, XOR PARITY_ODD
out_count  output  CNT_W  frame beats, modulo 2^CNT_W
out_ovf  output  1  frame held more than 2^CNT_W-1 beats

Behaviour:
- Reset (rst_n=0, asynchronous):
  - acc, cnt, ovf_acc, out_sum, out_count, out_parity, out_ovf and out_valid all go to 0 immediately.
  - State goes to ACC.
  - After reset, in_ready=1. Words presented while rst_n=0 are ignored.
- States:
  - ACC (collecting words, including the idle case where acc=0 and cnt=0).
  - HOLD (result pending).
- Handshake outputs: in_ready = (state==ACC); out_valid = (state==HOLD). Both are decoded from a registered state with no combinational input-to-output paths.
- Accept: in_valid && in_ready at a rising edge. While in_valid=0, in_data and in_last are don't-care.
- ACC, accepted word, in_last=0:
  - acc <= acc ^ in_data; cnt <= cnt+1 (wraps).
  - ovf_acc is set if cnt was all-ones.
- ACC, accepted word, in_last=1:
  - out_sum <= acc ^ in_data.
  - out_parity <= ^(acc ^ in_data) ^ PARITY_ODD.
  - out_count <= cnt+1 (wraps).
  - out_ovf <= ovf_acc | (cnt==all-ones).
  - acc, cnt and ovf_acc clear to 0; state goes to HOLD.
  - Latency: out_valid rises 1 cycle after the last word is accepted. Single-word frames are legal.
- HOLD:
  - out_* stay stable while out_ready=0; in_valid is not consumed.
  - When out_ready=1: state goes to ACC at that edge, out_valid=0 and in_ready=1 the next cycle.
  - Minimum spacing is one bubble cycle between the last word of a frame and the first word of the next.
- clr=1 (synchronous, highest priority after reset):
  - acc, cnt, ovf_acc and out_valid go to 0; state goes to ACC.
  - A word accepted or a result handshake in the same cycle is discarded.
  - out_sum, out_count and out_parity hold their old values (don't-care once out_valid=0).
- Gaps in in_valid mid-frame do not affect the result.

Test Plan:
- WIDTH=8: words 0x0F, 0xF0, 0x55(last), out_ready=1 -> one cycle after the 0x55 accept: out_valid=1, out_sum=0xAA, out_parity=0, out_count=3, out_ovf=0; the next cycle in_ready=1.
- Single word 0x01(last) -> out_sum=0x01, out_parity=1, out_count=1. Rerun with PARITY_ODD=1 -> out_parity=0.
- Backpressure: frame 0x12, 0x34(last), out_ready=0 for 5 cycles while in_valid=1 with 0x99 -> in_ready=0, out_sum=0x26 stable, 0x99 not consumed. Then out_ready=1 -> 0x99 accepted two cycles after release.
- Mid-frame: 0x33, idle 3 cycles, then clr pulse, then 0x44(last) -> out_sum=0x44, out_count=1. A clr coincident with an accepted word discards that word.
- CNT_W=2: frame of 5 words, each 0x01 -> out_sum=0x01, out_count=1, out_ovf=1. Next frame of 3 words -> out_ovf=0, out_count=3.
- Assert rst_n=0 asynchronously mid-frame and during HOLD -> all outputs 0 before the next clk edge. After release, a fresh frame 0xA5(last) -> out_sum=0xA5, out_parity=0, out_count=1.
